debounce_go_stop_strobe: RTL

Front-end conditioning stage that sits directly upstream of one_shot_pulse_gen and drives its i_go and i_stop inputs. It takes two raw, asynchronous, bouncy control inputs and synchronizes and debounces each one. It then emits clean single-cycle go and stop strobes. A holdoff window after each go strobe rejects re-triggers while the downstream pulse is still running.

---
 rtl/debounce_go_stop_strobe.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/debounce_go_stop_strobe.sv
// Synchronizes and debounces raw go/stop lines and turns their debounced rising
// edges into single-cycle strobes, with a holdoff window that drops re-triggered go edges.

module debounce_go_stop_strobe_chan #(
    parameter int p_SYNC_STAGES     = 2,
    parameter int p_DEBOUNCE_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_level
);
    localparam int               lp_CW   = $clog2(p_DEBOUNCE_CYCLES) + 1;
    localparam logic [lp_CW-1:0] lp_LAST = lp_CW'(p_DEBOUNCE_CYCLES - 1);
    localparam logic [lp_CW-1:0] lp_ONE  = lp_CW'(1);

    localparam logic [1:0] ST_STABLE_LO = 2'd0;
    localparam logic [1:0] ST_CHK_HI    = 2'd1;
    localparam logic [1:0] ST_STABLE_HI = 2'd2;
    localparam logic [1:0] ST_CHK_LO    = 2'd3;

    logic [p_SYNC_STAGES-1:0] r_sync;
    logic [1:0]               r_state;
    logic [lp_CW-1:0]         r_count;
    logic                     r_level;
    logic                     w_sample;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[p_SYNC_STAGES-2:0], i_raw};
        end
    end

    assign w_sample = r_sync[p_SYNC_STAGES-1];

    // The count reaches LAST on the D-th consecutive sample, so it never wraps.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_STABLE_LO;
            r_count <= '0;
            r_level <= 1'b0;
        end else begin
            case (r_state)
                ST_STABLE_LO: begin
                    if (w_sample) begin
                        r_state <= ST_CHK_HI;
                        r_count <= lp_ONE;
                    end
                end
                ST_CHK_HI: begin
                    if (!w_sample) begin
                        r_state <= ST_STABLE_LO;
                        r_count <= '0;
                    end else if (r_count == lp_LAST) begin
                        r_state <= ST_STABLE_HI;
                        r_count <= '0;
                        r_level <= 1'b1;
                    end else begin
                        r_count <= r_count + lp_ONE;
                    end
                end
                ST_STABLE_HI: begin
                    if (!w_sample) begin
                        r_state <= ST_CHK_LO;
                        r_count <= lp_ONE;
                    end
                end
                ST_CHK_LO: begin
                    if (w_sample) begin
                        r_state <= ST_STABLE_HI;
                        r_count <= '0;
                    end else if (r_count == lp_LAST) begin
                        r_state <= ST_STABLE_LO;
                        r_count <= '0;
                        r_level <= 1'b0;
                    end else begin
                        r_count <= r_count + lp_ONE;
                    end
                end
                default: begin
                    r_state <= ST_STABLE_LO;
                    r_count <= '0;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    assign o_level = r_level;
endmodule

module debounce_go_stop_strobe #(
    parameter int p_SYNC_STAGES     = 2,
    parameter int p_DEBOUNCE_CYCLES = 16,
    parameter int p_HOLDOFF_CYCLES  = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_go_raw,
    input  logic i_stop_raw,
    output logic o_go,
    output logic o_stop,
    output logic o_go_level,
    output logic o_stop_level,
    output logic o_go_dropped,
    output logic o_holdoff
);
    localparam int               lp_HW   = (p_HOLDOFF_CYCLES < 1) ? 1 : $clog2(p_HOLDOFF_CYCLES + 1);
    localparam logic [lp_HW-1:0] lp_HOLD = lp_HW'(p_HOLDOFF_CYCLES);
    localparam logic [lp_HW-1:0] lp_HONE = lp_HW'(1);

    logic             w_go_level;
    logic             w_stop_level;
    logic             r_go_level_q;
    logic             r_stop_level_q;
    logic             w_go_rise;
    logic             w_stop_rise;
    logic             w_hold_zero;
    logic             w_go_accept;
    logic [lp_HW-1:0] w_holdoff_next;
    logic [lp_HW-1:0] r_holdoff_cnt;
    logic             r_go;
    logic             r_stop;
    logic             r_go_dropped;
    logic             r_holdoff;

    debounce_go_stop_strobe_chan #(
        .p_SYNC_STAGES    (p_SYNC_STAGES),
        .p_DEBOUNCE_CYCLES(p_DEBOUNCE_CYCLES)
    ) u_go_chan (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_raw  (i_go_raw),
        .o_level(w_go_level)
    );

    debounce_go_stop_strobe_chan #(
        .p_SYNC_STAGES    (p_SYNC_STAGES),
        .p_DEBOUNCE_CYCLES(p_DEBOUNCE_CYCLES)
    ) u_stop_chan (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_raw  (i_stop_raw),
        .o_level(w_stop_level)
    );

    assign w_go_rise   = w_go_level & ~r_go_level_q;
    assign w_stop_rise = w_stop_level & ~r_stop_level_q;
    assign w_hold_zero = (r_holdoff_cnt == '0);
    // Stop always wins over a coincident go edge.
    assign w_go_accept = w_go_rise & w_hold_zero & ~w_stop_rise;

    always_comb begin
        w_holdoff_next = r_holdoff_cnt;
        if (w_stop_rise) begin
            w_holdoff_next = '0;
        end else if (w_go_accept) begin
            w_holdoff_next = lp_HOLD;
        end else if (!w_hold_zero) begin
            w_holdoff_next = r_holdoff_cnt - lp_HONE;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_go_level_q   <= 1'b0;
            r_stop_level_q <= 1'b0;
            r_holdoff_cnt  <= '0;
            r_go           <= 1'b0;
            r_stop         <= 1'b0;
            r_go_dropped   <= 1'b0;
            r_holdoff      <= 1'b0;
        end else begin
            r_go_level_q   <= w_go_level;
            r_stop_level_q <= w_stop_level;
            r_holdoff_cnt  <= w_holdoff_next;
            r_go           <= w_go_accept;
            r_stop         <= w_stop_rise;
            r_go_dropped   <= w_go_rise & ~w_go_accept;
            r_holdoff      <= (w_holdoff_next != '0);
        end
    end

    assign o_go         = r_go;
    assign o_stop       = r_stop;
    assign o_go_level   = w_go_level;
    assign o_stop_level = w_stop_level;
    assign o_go_dropped = r_go_dropped;
    assign o_holdoff    = r_holdoff;
endmodule
